jt51_interp: RTL
================

# jt51_interp

Linear interpolator that converts the JT51 audio-rate sample stream into a one-sample-per-clock stream for the second-order sigma-delta DAC stage directly downstream, which requires input rate equal to its clock rate. Each accepted sample becomes the end point of a straight-line segment spanning exactly 2^RATIO_W clocks. The segment is built by an exact fixed-point accumulator, so it ends on the target value with no drift. A one-entry holding register absorbs input jitter, and underrun/overrun are reported as single-cycle pulses.

## Interface
- WIDTH, 16, sample width (signed, two's complement), in and out
- RATIO_W, 6, log2 of clocks per input sample; valid range 1..10
- clk  in  1  system clock; same clock as the DAC stage
- rst_n  in  1  reset, asynchronous, active-low
- din  in  WIDTH  signed input sample
- din_valid  in  1  single-cycle strobe; din is captured when high
- dout  out  WIDTH  signed interpolated sample, registered, new value every clock
- seg_start  out  1  one-cycle pulse on the clock a new segment is loaded
- underrun  out  1  one-cycle pulse when a segment ends with no sample pending
- overrun  out  1  one-cycle pulse when a pending sample is overwritten before use

## Operation
Internal state:
- prev and target, each WIDTH bits.
- diff = target − prev, WIDTH+1 bits signed.
- acc, WIDTH+RATIO_W bits signed, scaled by 2^RATIO_W.
- cnt, RATIO_W bits.
- hold register and pending flag.

State machine has three states: IDLE, RUN and HOLD.
- **IDLE (reset state):** dout=0. On din_valid, load prev=0, target=din, acc=0 and cnt=0, then go to RUN.
- **RUN:** every clock, acc<=acc+diff, cnt<=cnt+1, dout<=(acc+diff)>>>RATIO_W (arithmetic shift, floor). On the clock where cnt==2^RATIO_W−1, the segment ends: acc equals target·2^RATIO_W exactly and dout=target.
  - Segment end with pending set: prev<=target, target<=hold, acc<=target<<RATIO_W, cnt<=0, clear pending, pulse seg_start on the next clock. Stay in RUN.
  - Segment end with pending clear and no din_valid: go to HOLD and pulse underrun.
- **HOLD:** dout frozen at target; acc and cnt are static. On din_valid, prev<=target, target<=din, acc<=target<<RATIO_W, cnt<=0, pulse seg_start, then go to RUN.

Input capture:
- din_valid in RUN with pending clear: hold<=din, pending<=1.
- din_valid in RUN with pending set and no segment end this clock: hold<=din (newest sample wins) and pulse overrun.
- din_valid on a segment-end clock with pending set: the old hold value is loaded into the segment, the new din goes into hold, pending stays 1. No overrun.
- din_valid on a segment-end clock with pending clear: din bypasses hold straight into target. No underrun.

Arithmetic rule: |diff| never exceeds 2^WIDTH−1 and acc stays within target range, so no saturation is needed in the base datapath.

## Timing
- Reset values: dout=0, seg_start=0, underrun=0, overrun=0, state=IDLE, pending=0, acc=0, cnt=0. Reset asserted mid-segment aborts it immediately, asynchronously.
- Latency from IDLE: din_valid at clock t, first ramp value on dout at t+2, dout=din at t+1+2^RATIO_W.
- Latency in steady state: a sample captured in hold becomes target at the next segment end, and is reached on dout 2^RATIO_W clocks later.
- Flags are registered and assert the clock after their triggering event; each lasts one clock.
- Throughput: at most one sample per 2^RATIO_W clocks without overrun.

## Configuration
- JT51_INTERP_DITHER_EN defined:
  - Adds a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'h0001 on reset) that advances every clock in RUN.
  - The output becomes dout<=sat((acc+diff+lfsr[RATIO_W-1:0])>>>RATIO_W), which is TPDF-free rectangular rounding dither.
  - Result is saturated to the WIDTH range; saturation is needed only at the positive full-scale limit.
  - In HOLD the LFSR stops and dout=target exactly.
- JT51_INTERP_DITHER_EN undefined: no LFSR is present and dout is plain floor truncation, bit-exact to the Operation section.

## Structure
- Shared package jt51_interp_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, HOLD=2'd2);
  - the LFSR seed and tap mask constants.
- Sub-module jt51_interp_lfsr implements the dither generator. It is instantiated only under JT51_INTERP_DITHER_EN.

## Test plan
- WIDTH=16, RATIO_W=2, reset then din=400 strobe → dout 100,200,300,400 on the 4 clocks after the first RUN clock; seg_start high for one clock.
- Continue with din=0 pending before segment end → dout 300,200,100,0, no underrun.
- No further input after the 0 segment → underrun pulses once, dout holds 0 indefinitely; then din=−32768 → ramp −8192,−16384,−24576,−32768.
- Two din_valid strobes (5, then 9) within one segment → overrun pulses once; next segment targets 9.
- din_valid exactly on a segment-end clock with pending clear → loaded directly, no underrun, seg_start on the following clock.
- rst_n low mid-ramp → dout=0 and state IDLE immediately. With DITHER_EN, 32767 held for 1000 clocks → dout never wraps negative.

Source files
------------

// File: rtl/jt51_interp_pkg.sv
// jt51_interp_pkg: shared definitions for the JT51 output interpolator.
// Holds the segment state encoding and the dither LFSR constants.
package jt51_interp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'h0001;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One LFSR advance: shift left, feedback is the parity of the tapped bits
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/jt51_interp_lfsr.sv
// jt51_interp_lfsr: dither source for the interpolator. Free-running while
// enabled, frozen otherwise; exposes only the low OUT_W bits as the dither word.
module jt51_interp_lfsr
  import jt51_interp_pkg::*;
#(
  parameter int OUT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [OUT_W-1:0] dither
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next LFSR value: advance only while enabled
  always_comb begin
    if (en) begin
      lfsr_d = lfsr_step(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR register, seeded on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign dither = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/jt51_interp.sv
// jt51_interp: linear interpolator from the JT51 sample rate up to one sample
// per clock. Each accepted sample ends a straight segment of 2^RATIO_W clocks
// built by an exact accumulator. Optional rounding dither is enabled by
// defining JT51_INTERP_DITHER_EN.
module jt51_interp
  import jt51_interp_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int RATIO_W = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] din,
  input  logic                    din_valid,
  output logic signed [WIDTH-1:0] dout,
  output logic                    seg_start,
  output logic                    underrun,
  output logic                    overrun
);

  localparam int AW = WIDTH + RATIO_W;
  localparam logic [RATIO_W-1:0] CNT_ONE  = RATIO_W'(1'b1);
  localparam logic [RATIO_W-1:0] CNT_LAST = '1;

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] prev_q, prev_d;
  logic signed [WIDTH-1:0] target_q, target_d;
  logic signed [WIDTH-1:0] hold_q, hold_d;
  logic                    pending_q, pending_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic [RATIO_W-1:0]      cnt_q, cnt_d;
  logic signed [WIDTH-1:0] dout_q, dout_d;
  logic                    seg_start_q, seg_start_d;
  logic                    underrun_q, underrun_d;
  logic                    overrun_q, overrun_d;

  logic signed [WIDTH:0]   diff_s;
  logic signed [AW-1:0]    diff_ext_s;
  logic signed [AW-1:0]    sum_s;
  logic signed [AW-1:0]    tgt_scaled_s;
  logic signed [WIDTH-1:0] ramp_s;
  logic                    seg_end_s;
  logic                    run_s;

  assign diff_s       = (WIDTH+1)'(target_q) - (WIDTH+1)'(prev_q);
  assign diff_ext_s   = AW'(diff_s);
  assign sum_s        = acc_q + diff_ext_s;
  assign tgt_scaled_s = {target_q, {RATIO_W{1'b0}}};
  assign seg_end_s    = (cnt_q == CNT_LAST);
  assign run_s        = (state_q == RUN);

`ifdef JT51_INTERP_DITHER_EN
  logic [RATIO_W-1:0]    dither_s;
  logic                  carry_s;
  logic signed [WIDTH:0] dith_sum_s;

  jt51_interp_lfsr #(.OUT_W(RATIO_W)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (run_s),
    .dither (dither_s)
  );

  // Dithered output: floor((sum + dither) / 2^RATIO_W), clipped at positive full scale
  always_comb begin
    carry_s    = (sum_s[RATIO_W-1:0] > ~dither_s);
    dith_sum_s = {sum_s[AW-1], sum_s[AW-1:RATIO_W]} + {{WIDTH{1'b0}}, carry_s};
    if (dith_sum_s[WIDTH] != dith_sum_s[WIDTH-1]) begin
      ramp_s = {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      ramp_s = dith_sum_s[WIDTH-1:0];
    end
  end
`else
  // Top WIDTH bits of the scaled sum are the arithmetic-shift floor
  assign ramp_s = sum_s[AW-1:RATIO_W];
`endif

  // Segment sequencing, input capture and output/flag next values
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    target_d    = target_q;
    hold_d      = hold_q;
    pending_d   = pending_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    dout_d      = dout_q;
    seg_start_d = 1'b0;
    underrun_d  = 1'b0;
    overrun_d   = 1'b0;
    case (state_q)
      IDLE: begin
        dout_d = '0;
        if (din_valid) begin
          prev_d      = '0;
          target_d    = din;
          acc_d       = '0;
          cnt_d       = '0;
          seg_start_d = 1'b1;
          state_d     = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d  = sum_s;
        cnt_d  = cnt_q + CNT_ONE;
        dout_d = ramp_s;
        if (seg_end_s) begin
          if (pending_q) begin
            // Pending sample starts the next segment; a new strobe refills hold
            prev_d      = target_q;
            target_d    = hold_q;
            acc_d       = tgt_scaled_s;
            cnt_d       = '0;
            seg_start_d = 1'b1;
            if (din_valid) begin
              hold_d    = din;
              pending_d = 1'b1;
            end else begin
              pending_d = 1'b0;
            end
          end else if (din_valid) begin
            // Strobe on the last clock goes straight into the next segment
            prev_d      = target_q;
            target_d    = din;
            acc_d       = tgt_scaled_s;
            cnt_d       = '0;
            seg_start_d = 1'b1;
          end else begin
            state_d    = HOLD;
            underrun_d = 1'b1;
          end
        end else if (din_valid) begin
          hold_d    = din;
          pending_d = 1'b1;
          overrun_d = pending_q;
        end else begin
          pending_d = pending_q;
        end
      end
      HOLD: begin
        dout_d = target_q;
        if (din_valid) begin
          prev_d      = target_q;
          target_d    = din;
          acc_d       = tgt_scaled_s;
          cnt_d       = '0;
          seg_start_d = 1'b1;
          state_d     = RUN;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
        dout_d  = '0;
      end
    endcase
  end

  // State, datapath and flag registers; reset aborts any segment at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      target_q    <= '0;
      hold_q      <= '0;
      pending_q   <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      dout_q      <= '0;
      seg_start_q <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      target_q    <= target_d;
      hold_q      <= hold_d;
      pending_q   <= pending_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      dout_q      <= dout_d;
      seg_start_q <= seg_start_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
    end
  end

  assign dout      = dout_q;
  assign seg_start = seg_start_q;
  assign underrun  = underrun_q;
  assign overrun   = overrun_q;

endmodule
